// File: rtl/board_fetch.sv
`default_nettype none
// ============================================================================
// Module   : board_fetch
// Purpose  : On each frame_start, copies NUM_CELLS BRAM words into the display
//            cell bank. Define BOARD_FETCH_SHADOW_EN to buffer captures in a
//            shadow bank that is copied to the cells in one edge at COMMIT.
// Revision : 1.0 - initial release
// ============================================================================
module board_fetch #(
    parameter int                    WIDTH      = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h100,
    parameter int                    NUM_CELLS  = 30
) (
    input  logic                       clk50MHz,
    input  logic                       clr,
    input  logic                       frame_start,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [WIDTH-1:0]           mem_data,
    output logic [NUM_CELLS*WIDTH-1:0] cells,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int               IDX_W      = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_LAST   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_overrun;
    logic [WIDTH-1:0]        r_cell [NUM_CELLS];
    logic                    w_capture;
    logic [IDX_W-1:0]        w_cap_idx;

    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read data lags its address by one cycle, so each FETCH cycle with
    // index > 0 lands the word requested in the previous cycle.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_cap_idx    = r_idx - IDX_W'(1);
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_capture = (r_idx != '0);
                if (r_idx == c_last_idx) begin
                    w_state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                w_capture    = 1'b1;
                w_cap_idx    = c_last_idx;
                w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            r_idx     <= '0;
            r_addr    <= BASE_ADDR;
            r_overrun <= 1'b0;
        end else begin
            if (frame_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == ST_FETCH) && (r_idx != c_last_idx)) begin
                r_idx  <= r_idx + IDX_W'(1);
                r_addr <= BASE_ADDR + ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(1);
            end else begin
                r_idx  <= '0;
                r_addr <= BASE_ADDR;
            end
        end
    end

`ifdef BOARD_FETCH_SHADOW_EN
    logic [WIDTH-1:0] r_shadow [NUM_CELLS];

    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_shadow[i] <= '0;
                r_cell[i]   <= '0;
            end
        end else begin
            if (w_capture) begin
                r_shadow[w_cap_idx] <= mem_data;
            end
            // The final word bypasses the shadow so the whole bank flips at once.
            if (r_state == ST_LAST) begin
                for (int i = 0; i < NUM_CELLS - 1; i++) begin
                    r_cell[i] <= r_shadow[i];
                end
                r_cell[NUM_CELLS-1] <= mem_data;
            end
        end
    end
`else
    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_cell[i] <= '0;
            end
        end else if (w_capture) begin
            r_cell[w_cap_idx] <= mem_data;
        end
    end
`endif

    generate
        for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cells
            assign cells[g*WIDTH +: WIDTH] = r_cell[g];
        end
    endgenerate

    assign mem_addr   = r_addr;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_COMMIT);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_board_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_fetch
// Purpose  : Scoreboard bench for board_fetch (default base and wrapping base).
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_fetch;

    localparam int             WIDTH  = 16;
    localparam int             AW     = 10;
    localparam int             N      = 30;
    localparam int             LAT    = N + 2;
    localparam logic [AW-1:0]  BASE_A = 10'h100;
    localparam logic [AW-1:0]  BASE_B = 10'h3F0;

    typedef struct {
        logic [N*WIDTH-1:0] cells;
        int                 start;
    } frame_t;

    logic               clk50MHz = 1'b0;
    logic               clr      = 1'b0;
    logic               fs_a     = 1'b0;
    logic               fs_b     = 1'b0;
    logic [AW-1:0]      addr_a, addr_b;
    logic [WIDTH-1:0]   data_a   = '0;
    logic [WIDTH-1:0]   data_b   = '0;
    logic [N*WIDTH-1:0] cells_a, cells_b;
    logic               busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;
    logic [WIDTH-1:0]   mem [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    frame_t        q_frm_a[$], q_frm_b[$];
    logic [AW-1:0] q_adr_a[$], q_adr_b[$];
    frame_t        fa, fb;
    logic [N*WIDTH-1:0] old_cells;

    board_fetch #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE_A), .NUM_CELLS(N)) u_dut_a (
        .clk50MHz(clk50MHz), .clr(clr), .frame_start(fs_a), .mem_addr(addr_a),
        .mem_data(data_a), .cells(cells_a), .busy(busy_a), .frame_done(done_a),
        .overrun(ovr_a)
    );

    board_fetch #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE_B), .NUM_CELLS(N)) u_dut_b (
        .clk50MHz(clk50MHz), .clr(clr), .frame_start(fs_b), .mem_addr(addr_b),
        .mem_data(data_b), .cells(cells_b), .busy(busy_b), .frame_done(done_b),
        .overrun(ovr_b)
    );

    always #10 clk50MHz = ~clk50MHz;

    // One-cycle-latency BRAM model shared by both instances.
    always @(posedge clk50MHz) begin
        cyc    <= cyc + 1;
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] cell_of(input logic [N*WIDTH-1:0] v, input int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    task automatic start_fetch(input bit sel);
        frame_t        f;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        base    = sel ? BASE_B : BASE_A;
        f.start = cyc;
        for (int i = 0; i < N; i++) begin
            a = base + AW'(i);
            f.cells[i*WIDTH +: WIDTH] = mem[a];
            if (sel) q_adr_b.push_back(a); else q_adr_a.push_back(a);
        end
        repeat (2) begin
            if (sel) q_adr_b.push_back(base); else q_adr_a.push_back(base);
        end
        if (sel) begin
            q_frm_b.push_back(f);
            fs_b = 1'b1;
        end else begin
            q_frm_a.push_back(f);
            fs_a = 1'b1;
        end
        @(negedge clk50MHz);
        fs_a = 1'b0;
        fs_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk50MHz);
            if (sel ? (!busy_b && q_frm_b.size() == 0) : (!busy_a && q_frm_a.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(sel ? "idle_timeout_b" : "idle_timeout_a", 64'(ok), 64'd1);
        chk(sel ? "addr_q_drained_b" : "addr_q_drained_a",
            64'(sel ? q_adr_b.size() : q_adr_a.size()), 64'd0);
    endtask

    // Monitors: one expected address per busy cycle, one frame per frame_done.
    always @(negedge clk50MHz) begin
        if (busy_a) begin
            if (q_adr_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL addr_a: unexpected busy cycle, mem_addr=%0h expected idle", addr_a);
            end else begin
                chk("addr_a", 64'(addr_a), 64'(q_adr_a.pop_front()));
            end
        end
        if (done_a) begin
            if (q_frm_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done_a: unexpected frame_done at cycle %0d expected none", cyc);
            end else begin
                fa = q_frm_a.pop_front();
                chk("latency_a", 64'(cyc - fa.start), 64'(LAT));
                for (int i = 0; i < N; i++)
                    chk($sformatf("cell_a[%0d]", i), 64'(cell_of(cells_a, i)), 64'(cell_of(fa.cells, i)));
            end
        end
        if (busy_b) begin
            if (q_adr_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL addr_b: unexpected busy cycle, mem_addr=%0h expected idle", addr_b);
            end else begin
                chk("addr_b", 64'(addr_b), 64'(q_adr_b.pop_front()));
            end
        end
        if (done_b) begin
            if (q_frm_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done_b: unexpected frame_done at cycle %0d expected none", cyc);
            end else begin
                fb = q_frm_b.pop_front();
                chk("latency_b", 64'(cyc - fb.start), 64'(LAT));
                for (int i = 0; i < N; i++)
                    chk($sformatf("cell_b[%0d]", i), 64'(cell_of(cells_b, i)), 64'(cell_of(fb.cells, i)));
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk50MHz);
        chk("rst_addr",    64'(addr_a), 64'h100);
        chk("rst_busy",    64'(busy_a), 64'd0);
        chk("rst_done",    64'(done_a), 64'd0);
        chk("rst_overrun", 64'(ovr_a),  64'd0);
        chk("rst_cells",   64'(cells_a == '0), 64'd1);
        clr = 1'b1;
        @(negedge clk50MHz);

        // Basic fetch
        for (int i = 0; i < N; i++) mem[BASE_A + AW'(i)] = WIDTH'(16'hA000 + i);
        start_fetch(1'b0);
        wait_idle(1'b0);
        chk("basic_overrun", 64'(ovr_a), 64'd0);

        // Second fetch with new data: visibility of intermediate cells
        old_cells = cells_a;
        for (int i = 0; i < N; i++) mem[BASE_A + AW'(i)] = WIDTH'(16'h5000 + i);
        start_fetch(1'b0);
`ifdef BOARD_FETCH_SHADOW_EN
        repeat (LAT - 2) @(negedge clk50MHz);
        for (int i = 0; i < N; i++)
            chk($sformatf("shadow_hold[%0d]", i), 64'(cell_of(cells_a, i)), 64'(cell_of(old_cells, i)));
`else
        @(negedge clk50MHz);
        chk("direct_cell0_before", 64'(cell_of(cells_a, 0)), 64'h0000A000);
        @(negedge clk50MHz);
        chk("direct_cell0_after",  64'(cell_of(cells_a, 0)), 64'h00005000);
        chk("direct_cell1_before", 64'(cell_of(cells_a, 1)), 64'h0000A001);
`endif
        wait_idle(1'b0);

        // Overrun: extra frame_start 10 cycles into the fetch
        for (int i = 0; i < N; i++) mem[BASE_A + AW'(i)] = WIDTH'(16'h7700 + i);
        start_fetch(1'b0);
        repeat (9) @(negedge clk50MHz);
        fs_a = 1'b1;
        @(negedge clk50MHz);
        fs_a = 1'b0;
        chk("overrun_set", 64'(ovr_a), 64'd1);
        wait_idle(1'b0);
        repeat (5) @(negedge clk50MHz);
        chk("overrun_sticky", 64'(ovr_a), 64'd1);
        clr = 1'b0;
        @(negedge clk50MHz);
        clr = 1'b1;
        chk("overrun_cleared", 64'(ovr_a), 64'd0);
        @(negedge clk50MHz);

        // Reset at cycle 15 of a fetch, with frame_start held during reset
        for (int i = 0; i < 15; i++) q_adr_a.push_back(BASE_A + AW'(i));
        fs_a = 1'b1;
        @(negedge clk50MHz);
        fs_a = 1'b0;
        repeat (14) @(negedge clk50MHz);
        clr  = 1'b0;
        fs_a = 1'b1;
        @(negedge clk50MHz);
        clr  = 1'b1;
        fs_a = 1'b0;
        chk("midrst_busy",  64'(busy_a), 64'd0);
        chk("midrst_addr",  64'(addr_a), 64'h100);
        chk("midrst_cells", 64'(cells_a == '0), 64'd1);
        repeat (40) @(negedge clk50MHz);
        chk("midrst_still_idle", 64'(busy_a), 64'd0);
        chk("midrst_addr_q", 64'(q_adr_a.size()), 64'd0);

        // Back-to-back fetches
        for (int i = 0; i < N; i++) mem[BASE_A + AW'(i)] = WIDTH'(16'h1200 + i);
        start_fetch(1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (done_a) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk50MHz);
            end
            chk("b2b_first_done_seen", 64'(seen), 64'd1);
        end
        for (int i = 0; i < N; i++) mem[BASE_A + AW'(i)] = WIDTH'(16'h3000 + i);
        @(negedge clk50MHz);
        start_fetch(1'b0);
        wait_idle(1'b0);
        chk("b2b_overrun", 64'(ovr_a), 64'd0);

        // Address wrap-around on the high-base instance
        for (int i = 0; i < N; i++) mem[BASE_B + AW'(i)] = WIDTH'(16'hC000 + i);
        start_fetch(1'b1);
        wait_idle(1'b1);
        chk("wrap_overrun", 64'(ovr_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
